// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel sequencer: prescaled ramp steps through six hue segments and
// produces RGB duty values that refresh only at PWM period boundaries.

// One duty channel. Every channel follows the same six-segment pattern,
// rotated by OFFSET segments relative to red.
module rgb_hue_lane #(
  parameter int DUTY_W = 8,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [2:0]        seg,
  input  logic [DUTY_W-1:0] level,
  output logic [DUTY_W-1:0] duty
);
  localparam logic [DUTY_W-1:0] MAX = {DUTY_W{1'b1}};

  logic [3:0]        rot_raw, rot;
  logic [DUTY_W-1:0] up, down, val;
  logic [DUTY_W-1:0] duty_d, duty_q;

  assign up      = level;
  assign down    = MAX - level;
  assign rot_raw = {1'b0, seg} + 4'(OFFSET);
  assign rot     = (rot_raw >= 4'd6) ? rot_raw - 4'd6 : rot_raw;

  // Red's pattern: MAX, down, 0, 0, up, MAX
  always_comb begin
    val = '0;
    if (seg <= 3'd5) begin
      case (rot)
        4'd0:    val = MAX;
        4'd1:    val = down;
        4'd4:    val = up;
        4'd5:    val = MAX;
        default: val = '0;
      endcase
    end
  end

  always_comb begin
    duty_d = duty_q;
    if (load) duty_d = val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_q <= '0;
    else        duty_q <= duty_d;
  end

  assign duty = duty_q;
endmodule

module rgb_hue_sequencer #(
  parameter int DUTY_W    = 8,
  parameter int STEP_CLKS = 7812
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pwm_wrap,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        seg,
  output logic              cycle_done
);
  localparam int                PRE_W    = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_CLKS - 1);
  localparam logic [DUTY_W-1:0] MAX      = {DUTY_W{1'b1}};

  logic [PRE_W-1:0]  pre_d, pre_q;
  logic [DUTY_W-1:0] level_d, level_q;
  logic [2:0]        seg_d, seg_q;
  logic              cycle_done_d, cycle_done_q;
  logic              tick;

  logic [2:0][DUTY_W-1:0] duty;

  assign tick = enable && (pre_q == PRE_LAST);

  always_comb begin
    pre_d        = pre_q;
    level_d      = level_q;
    seg_d        = seg_q;
    cycle_done_d = 1'b0;
    if (enable) pre_d = tick ? '0 : pre_q + 1'b1;
    // Illegal segment codes recover to the start of the wheel.
    if (seg_q > 3'd5) begin
      seg_d   = 3'd0;
      level_d = '0;
    end else if (tick) begin
      if (level_q == MAX) begin
        level_d = '0;
        if (seg_q == 3'd5) begin
          seg_d        = 3'd0;
          cycle_done_d = 1'b1;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end else begin
        level_d = level_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      level_q      <= '0;
      seg_q        <= 3'd0;
      cycle_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      level_q      <= level_d;
      seg_q        <= seg_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Lane 0 = red, 1 = green (4 segments ahead), 2 = blue (2 segments ahead)
  for (genvar i = 0; i < 3; i++) begin : g_lane
    rgb_hue_lane #(
      .DUTY_W (DUTY_W),
      .OFFSET ((i == 0) ? 0 : (i == 1) ? 4 : 2)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pwm_wrap),
      .seg   (seg_q),
      .level (level_q),
      .duty  (duty[i])
    );
  end

  assign duty_r     = duty[0];
  assign duty_g     = duty[1];
  assign duty_b     = duty[2];
  assign seg        = seg_q;
  assign cycle_done = cycle_done_q;
endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed bench for rgb_hue_sequencer at DUTY_W=4, STEP_CLKS=4.
module tb_rgb_hue_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       pwm_wrap = 1'b1;
  logic [3:0] duty_r, duty_g, duty_b;
  logic [2:0] seg;
  logic       cycle_done;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_hue_sequencer #(.DUTY_W(4), .STEP_CLKS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pwm_wrap   (pwm_wrap),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .seg        (seg),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // Colour table: {R, G, B} for segment s at ramp level l
  function automatic logic [11:0] exp_map(int s, int l);
    logic [3:0] u, d;
    u = 4'(l);
    d = 4'd15 - u;
    case (s)
      0: return {4'd15, u,     4'd0};
      1: return {d,     4'd15, 4'd0};
      2: return {4'd0,  4'd15, u};
      3: return {4'd0,  d,     4'd15};
      4: return {u,     4'd0,  4'd15};
      default: return {4'd15, 4'd0, d};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    pwm_wrap = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    pwm_wrap = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'h000) begin
      n_fail++; $display("FAIL reset_duty: got %h want 000", {duty_r, duty_g, duty_b});
    end
    n_tests++;
    if ({seg, cycle_done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_seg_done: got seg=%0d done=%0b want 0 0", seg, cycle_done);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'hF00 || seg !== 3'd0) begin
      n_fail++; $display("FAIL reset_first_wrap: got %h seg=%0d want f00 seg=0", {duty_r, duty_g, duty_b}, seg);
    end
  endtask

  task automatic test_ramp();
    logic [11:0] e;
    do_reset();
    for (int n = 1; n <= 72; n++) begin
      step();
      if (n <= 64) e = {4'd15, 4'((n - 1) / 4), 4'd0};
      else         e = {4'(15 - ((n - 1) / 4 - 16)), 4'd15, 4'd0};
      n_tests++;
      if ({duty_r, duty_g, duty_b} !== e || seg !== 3'(n / 64)) begin
        n_fail++;
        $display("FAIL ramp n=%0d: got %h seg=%0d want %h seg=%0d", n, {duty_r, duty_g, duty_b}, seg, e, n / 64);
      end
    end
  endtask

  task automatic test_full_wheel();
    int pulses, tp;
    logic [11:0] e;
    do_reset();
    pulses = 0;
    for (int n = 1; n <= 392; n++) begin
      step();
      tp = (n - 1) / 4;
      e  = exp_map((tp / 16) % 6, tp % 16);
      if (cycle_done === 1'b1) pulses++;
      n_tests++;
      if ({duty_r, duty_g, duty_b} !== e || seg !== 3'((n / 64) % 6) || cycle_done !== (n == 384)) begin
        n_fail++;
        $display("FAIL wheel n=%0d: got %h seg=%0d done=%0b want %h seg=%0d done=%0b",
                 n, {duty_r, duty_g, duty_b}, seg, cycle_done, e, (n / 64) % 6, n == 384);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL wheel_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    repeat (30) step();
    enable = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      n_tests++;
      if ({duty_r, duty_g, duty_b} !== 12'hF70 || seg !== 3'd0) begin
        n_fail++; $display("FAIL hold n=%0d: got %h seg=%0d want f70 seg=0", n, {duty_r, duty_g, duty_b}, seg);
      end
    end
    enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      n_tests++;
      if (duty_g !== ((n == 3) ? 4'd8 : 4'd7)) begin
        n_fail++; $display("FAIL hold_resume n=%0d: got g=%0d want %0d", n, duty_g, (n == 3) ? 8 : 7);
      end
    end
  endtask

  task automatic test_wrap_gating();
    logic [3:0] er, eg;
    do_reset();
    for (int n = 1; n <= 42; n++) begin
      pwm_wrap = (n % 10 == 0);
      step();
      er = (n < 10) ? 4'd0 : 4'd15;
      eg = (n < 10) ? 4'd0 : (n < 20) ? 4'd2 : (n < 30) ? 4'd4 : (n < 40) ? 4'd7 : 4'd9;
      n_tests++;
      if (duty_r !== er || duty_g !== eg || duty_b !== 4'd0) begin
        n_fail++;
        $display("FAIL wrap_gate n=%0d: got %h want %h%h0", n, {duty_r, duty_g, duty_b}, er, eg);
      end
    end
    pwm_wrap = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (200) step();
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'h0EF || seg !== 3'd3) begin
      n_fail++; $display("FAIL async_pre: got %h seg=%0d want 0ef seg=3", {duty_r, duty_g, duty_b}, seg);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'h000 || seg !== 3'd0 || cycle_done !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: got %h seg=%0d want 000 seg=0", {duty_r, duty_g, duty_b}, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'hF00 || seg !== 3'd0) begin
      n_fail++; $display("FAIL async_restart: got %h seg=%0d want f00 seg=0", {duty_r, duty_g, duty_b}, seg);
    end
    repeat (63) step();
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 12'hFF0 || seg !== 3'd1) begin
      n_fail++; $display("FAIL async_seg1: got %h seg=%0d want ff0 seg=1", {duty_r, duty_g, duty_b}, seg);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_wheel();
    test_enable_hold();
    test_wrap_gating();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
